// File: rtl/uvmc_tlm1_pkg.sv
// Shared types and constants for the uvmc_tlm1 put/get bridge.
package uvmc_tlm1_pkg;

  localparam int unsigned KEY_W_DEF = 64;

  typedef enum logic [1:0] {
    CMD_READ  = 2'd0,
    CMD_WRITE = 2'd1,
    CMD_NOP   = 2'd2
  } cmd_e;

  typedef struct packed {
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data;
  } packet_t;

  localparam int unsigned PKT_W = $bits(packet_t);

endpackage

// File: rtl/uvmc_tlm1_fifo.sv
// Synchronous FIFO with extra-MSB pointers; head data is read combinationally.
module uvmc_tlm1_fifo #(
  parameter int unsigned DW    = 66,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [DW-1:0]    wr_data,
  input  logic             pop,
  output logic [DW-1:0]    rd_data_c,
  output logic [CNT_W-1:0] count_c,
  output logic             full_c,
  output logic             empty_c
);

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DW-1:0]    mem_d [DEPTH];
  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             push_ok, pop_ok;

  assign count_c   = wr_ptr_q - rd_ptr_q;
  assign full_c    = (count_c == CNT_W'(DEPTH));
  assign empty_c   = (count_c == '0);
  assign push_ok   = push && !full_c;
  assign pop_ok    = pop && !empty_c;
  assign rd_data_c = empty_c ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data;
      wr_ptr_d                = wr_ptr_q + CNT_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uvmc_tlm1.sv
// Key-matched blocking-put bridge: producer and consumer register lookup keys,
// and once they match packets flow producer->consumer through a small FIFO.
module uvmc_tlm1
  import uvmc_tlm1_pkg::*;
#(
  parameter int unsigned KEY_W = KEY_W_DEF,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic             prod_key_vld,
  input  logic [KEY_W-1:0] prod_key,
  input  logic             cons_key_vld,
  input  logic [KEY_W-1:0] cons_key,
  output logic             connected,
  output logic             key_err,
  input  logic             put_vld,
  output logic             put_rdy,
  input  logic [PKT_W-1:0] put_pkt,
  output logic             get_vld,
  input  logic             get_rdy,
  output logic [PKT_W-1:0] get_pkt,
  output logic [CNT_W-1:0] count
);

  logic             prod_reg_q, prod_reg_d;
  logic             cons_reg_q, cons_reg_d;
  logic [KEY_W-1:0] prod_key_q, prod_key_d;
  logic [KEY_W-1:0] cons_key_q, cons_key_d;
  logic             connected_q, connected_d;
  logic             key_err_q, key_err_d;
  logic             fifo_full, fifo_empty;

  // Connection is judged from already-registered keys, so it lands one cycle
  // after the second registration.
  always_comb begin
    prod_reg_d  = prod_reg_q;
    cons_reg_d  = cons_reg_q;
    prod_key_d  = prod_key_q;
    cons_key_d  = cons_key_q;
    connected_d = connected_q;
    key_err_d   = key_err_q;

    if (prod_reg_q && cons_reg_q) begin
      if (prod_key_q == cons_key_q) connected_d = 1'b1;
      else                          key_err_d   = 1'b1;
    end

    if (prod_key_vld) begin
      if (prod_reg_q) begin
        key_err_d = 1'b1;
      end else begin
        prod_reg_d = 1'b1;
        prod_key_d = prod_key;
      end
    end

    if (cons_key_vld) begin
      if (cons_reg_q) begin
        key_err_d = 1'b1;
      end else begin
        cons_reg_d = 1'b1;
        cons_key_d = cons_key;
      end
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      prod_reg_q  <= 1'b0;
      cons_reg_q  <= 1'b0;
      prod_key_q  <= '0;
      cons_key_q  <= '0;
      connected_q <= 1'b0;
      key_err_q   <= 1'b0;
    end else begin
      prod_reg_q  <= prod_reg_d;
      cons_reg_q  <= cons_reg_d;
      prod_key_q  <= prod_key_d;
      cons_key_q  <= cons_key_d;
      connected_q <= connected_d;
      key_err_q   <= key_err_d;
    end
  end

  assign connected = connected_q;
  assign key_err   = key_err_q;
  assign put_rdy   = connected_q && !fifo_full;
  assign get_vld   = !fifo_empty;

  uvmc_tlm1_fifo #(
    .DW    (PKT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (nvdla_core_clk),
    .rst_n     (nvdla_core_rstn),
    .push      (put_vld && put_rdy),
    .wr_data   (put_pkt),
    .pop       (get_vld && get_rdy),
    .rd_data_c (get_pkt),
    .count_c   (count),
    .full_c    (fifo_full),
    .empty_c   (fifo_empty)
  );

endmodule

// File: tb/tb_uvmc_tlm1.sv
// Scoreboard bench for uvmc_tlm1: a cycle model predicts handshakes, connection
// state and FIFO contents; outputs are sampled on the falling edge.
module tb_uvmc_tlm1;
  import uvmc_tlm1_pkg::*;

  localparam int unsigned KEY_W = 64;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;
  localparam logic [KEY_W-1:0] FOO = 64'h0000_0000_0066_6F6F;
  localparam logic [KEY_W-1:0] BAR = 64'h0000_0000_0062_6172;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             prod_key_vld = 1'b0;
  logic [KEY_W-1:0] prod_key = '0;
  logic             cons_key_vld = 1'b0;
  logic [KEY_W-1:0] cons_key = '0;
  logic             connected, key_err;
  logic             put_vld = 1'b0;
  logic             put_rdy;
  logic [PKT_W-1:0] put_pkt = '0;
  logic             get_vld;
  logic             get_rdy = 1'b0;
  logic [PKT_W-1:0] get_pkt;
  logic [CNT_W-1:0] count;

  int errors = 0;
  int checks = 0;

  packet_t          sb[$];
  bit               mconn, merr, mp_reg, mc_reg;
  logic [KEY_W-1:0] mpk, mck;

  always #5 clk = ~clk;

  uvmc_tlm1 #(.KEY_W(KEY_W), .DEPTH(DEPTH)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .prod_key_vld    (prod_key_vld),
    .prod_key        (prod_key),
    .cons_key_vld    (cons_key_vld),
    .cons_key        (cons_key),
    .connected       (connected),
    .key_err         (key_err),
    .put_vld         (put_vld),
    .put_rdy         (put_rdy),
    .put_pkt         (put_pkt),
    .get_vld         (get_vld),
    .get_rdy         (get_rdy),
    .get_pkt         (get_pkt),
    .count           (count)
  );

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One clock: compare outputs against the model, then advance the model at the edge.
  task automatic cycle(output bit acc);
    bit      push, pop, nerr, exp_rdy;
    packet_t hd;
    @(negedge clk);
    exp_rdy = mconn && (sb.size() < DEPTH);
    chk("connected", 128'(connected), 128'(mconn));
    chk("key_err",   128'(key_err),   128'(merr));
    chk("put_rdy",   128'(put_rdy),   128'(exp_rdy));
    chk("get_vld",   128'(get_vld),   128'(sb.size() != 0));
    chk("count",     128'(count),     128'(sb.size()));
    if (sb.size() != 0) begin
      hd = sb[0];
      chk("get_pkt", 128'(get_pkt), 128'(hd));
    end else begin
      chk("get_pkt_empty", 128'(get_pkt), 128'(0));
    end
    push = rstn && put_vld && exp_rdy;
    pop  = rstn && get_rdy && (sb.size() != 0);
    acc  = push;
    @(posedge clk);
    if (!rstn) begin
      sb.delete();
      {mconn, merr, mp_reg, mc_reg} = '0;
      mpk = '0;
      mck = '0;
    end else begin
      if (pop)  void'(sb.pop_front());
      if (push) sb.push_back(packet_t'(put_pkt));
      nerr = merr;
      if (mp_reg && mc_reg) begin
        if (mpk == mck) mconn = 1'b1;
        else            nerr  = 1'b1;
      end
      if (prod_key_vld) begin
        if (mp_reg) nerr = 1'b1;
        else begin mp_reg = 1'b1; mpk = prod_key; end
      end
      if (cons_key_vld) begin
        if (mc_reg) nerr = 1'b1;
        else begin mc_reg = 1'b1; mck = cons_key; end
      end
      merr = nerr;
    end
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(acc);
  endtask

  task automatic send(input packet_t p, input int limit);
    bit acc = 1'b0;
    put_vld = 1'b1;
    put_pkt = p;
    for (int n = 0; n < limit && !acc; n++) cycle(acc);
    put_vld = 1'b0;
    if (!acc) chk("accept_timeout", 128'(acc), 128'(1));
  endtask

  task automatic drain();
    bit acc;
    get_rdy = 1'b1;
    for (int n = 0; n < 20 && sb.size() != 0; n++) cycle(acc);
    if (sb.size() != 0) chk("drain_timeout", 128'(sb.size()), 128'(0));
    idle(1);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    idle(2);
    rstn = 1'b1;
    idle(1);
  endtask

  task automatic reg_key(input bit prod, input logic [KEY_W-1:0] k);
    if (prod) begin prod_key_vld = 1'b1; prod_key = k; end
    else      begin cons_key_vld = 1'b1; cons_key = k; end
    idle(1);
    prod_key_vld = 1'b0;
    cons_key_vld = 1'b0;
  endtask

  function automatic packet_t mk(input logic [1:0] c, input logic [31:0] a, input logic [31:0] d);
    packet_t p;
    p.cmd  = c;
    p.addr = a;
    p.data = d;
    return p;
  endfunction

  initial begin
    bit acc;
    {mconn, merr, mp_reg, mc_reg} = '0;
    mpk = '0;
    mck = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Mismatched keys: never connect, producer stalls.
    reg_key(1'b1, FOO);
    reg_key(1'b0, BAR);
    put_vld = 1'b1;
    put_pkt = mk(CMD_WRITE, 32'h10, 32'hA5);
    for (int i = 0; i < 20; i++) begin
      cycle(acc);
      chk("mismatch_stall", 128'(acc), 128'(0));
    end
    put_vld = 1'b0;
    do_reset();

    // Matching keys in different cycles.
    reg_key(1'b1, FOO);
    idle(1);
    reg_key(1'b0, FOO);
    idle(2);

    // Back-to-back stream with consumer always ready.
    get_rdy = 1'b1;
    for (int i = 0; i < 8; i++) send(mk(CMD_WRITE, 32'(i), 32'hC0DE_0000 + 32'(i)), 10);
    drain();

    // Back-pressure: fill, stall, then full + pop with no bypass.
    get_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send(mk(CMD_READ, 32'h100 + 32'(i), 32'(i * 3)), 10);
    put_vld = 1'b1;
    put_pkt = mk(CMD_NOP, 32'h104, 32'h4);
    for (int i = 0; i < 3; i++) begin
      cycle(acc);
      chk("full_stall", 128'(acc), 128'(0));
    end
    get_rdy = 1'b1;
    cycle(acc);
    chk("full_no_bypass", 128'(acc), 128'(0));
    send(mk(CMD_NOP, 32'h104, 32'h4), 5);
    send(mk(CMD_WRITE, 32'h105, 32'h5), 5);
    drain();

    // Mid-stream reset with duplicate registration error.
    get_rdy = 1'b0;
    for (int i = 0; i < 3; i++) send(mk(CMD_WRITE, 32'h200 + 32'(i), 32'hFFFF_0000 | 32'(i)), 10);
    reg_key(1'b1, FOO);
    idle(1);
    rstn = 1'b0;
    idle(1);
    rstn = 1'b1;
    idle(1);
    prod_key_vld = 1'b1; prod_key = FOO;
    cons_key_vld = 1'b1; cons_key = FOO;
    idle(1);
    prod_key_vld = 1'b0;
    cons_key_vld = 1'b0;
    idle(2);
    send(mk(CMD_READ, 32'hDEAD_BEEF, 32'h1234_5678), 10);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uvmc_tlm1.md
Name: uvmc_tlm1

Overview:
- Hardware TLM1 blocking-put bridge: joins a producer put port to a consumer get port through a string-keyed connection.
- Each side registers a lookup key (e.g. "foo"). Once both keys match, the link is connected and packets flow producer→consumer through an internal FIFO with valid/ready flow control.
- Sits between a traffic producer and a consumer block, in place of a direct point-to-point wire-up.

Parameters:
- KEY_W, 64: lookup-key width in bits; ASCII string, left-padded with zeros ("foo" = 64'h0000_0000_0066_6F6F).
- PKT_W, 66: packet width = $bits(packet_t), i.e. {cmd[1:0], addr[31:0], data[31:0]}.
- DEPTH, 4: FIFO entries, power of two, ≥2.
- CNT_W, $clog2(DEPTH)+1: occupancy counter width.

Ports:
- nvdla_core_clk  in  1  sole clock; all logic rising-edge.
- nvdla_core_rstn  in  1  synchronous active-low reset.
- prod_key_vld  in  1  producer key registration strobe.
- prod_key  in  KEY_W  producer lookup key.
- cons_key_vld  in  1  consumer key registration strobe.
- cons_key  in  KEY_W  consumer lookup key.
- connected  out  1  keys registered and equal.
- key_err  out  1  sticky: key mismatch or duplicate registration.
- put_vld  in  1  producer offers packet.
- put_rdy  out  1  bridge accepts packet (blocking-put completion).
- put_pkt  in  PKT_W  producer packet.
- get_vld  out  1  packet available to consumer.
- get_rdy  in  1  consumer accepts packet.
- get_pkt  out  PKT_W  head-of-FIFO packet.
- count  out  CNT_W  FIFO occupancy.

Behaviour:
- Reset (nvdla_core_rstn low at a clock edge) clears:
  - both key registers and their "registered" flags;
  - connected=0, key_err=0;
  - FIFO pointers; count=0, get_vld=0, put_rdy=0;
  - get_pkt drives 0 while empty.
- Reset asserted mid-traffic discards all queued packets and drops the connection; both sides must re-register.
- Registration:
  - A *_key_vld strobe latches its key if that side is unregistered.
  - A strobe on an already-registered side is ignored and sets key_err.
  - Both strobes in the same cycle are both latched.
- Connected:
  - The cycle after both sides are registered, connected=1 if the keys are equal.
  - Otherwise key_err=1 and connected stays 0 until reset.
  - connected, once set, holds until reset.
- Put:
  - put_rdy = connected && (count < DEPTH); combinational from registered state, independent of put_vld.
  - Transfer occurs when put_vld && put_rdy at a clock edge; the packet is written at the tail.
  - Producer must hold put_vld/put_pkt stable until accepted.
- Get:
  - get_vld = (count != 0); get_pkt = head entry.
  - Pop occurs when get_vld && get_rdy.
- Latency: a packet accepted at edge N is visible on get_pkt/get_vld after edge N (one-cycle latency); no combinational put→get bypass.
- Simultaneous push and pop:
  - Both occur; count unchanged.
  - When full, put_rdy=0, so a same-cycle pop does not enable a push (no full bypass).
- Pointers wrap modulo DEPTH; count = wr_ptr − rd_ptr using an extra MSB.
- Ordering is strict FIFO; packets are never dropped or duplicated.
- Packets presented before connected are stalled (put_rdy=0), not dropped.

Decomposition:
- Package uvmc_tlm1_pkg holds:
  - typedef packet_t {logic [1:0] cmd; logic [31:0] addr; logic [31:0] data;};
  - cmd encodings: CMD_READ=0, CMD_WRITE=1, CMD_NOP=2;
  - localparam PKT_W=$bits(packet_t); KEY_W default.
- One sub-module, uvmc_tlm1_fifo: parameterised synchronous FIFO (push/pop/count/full/empty).
- Key registration and connect logic stay in the top.

Test Plan:
- Register prod_key="foo" and cons_key="foo" in different cycles → connected=1 exactly one cycle after the second registration; key_err=0.
- prod_key="foo", cons_key="bar" → connected stays 0, key_err=1; put_vld held high with put_pkt {1,32'h10,32'hA5} → put_rdy stays 0 for 20 cycles.
- Connected, get_rdy=1, stream 8 packets with addr 0..7 back-to-back → get_pkt emits addr 0..7 in order, each one cycle after acceptance; count never exceeds 1.
- Connected, get_rdy=0, offer 6 packets → first 4 accepted, count=4, put_rdy=0; raise get_rdy → packets drain in order, and the remaining 2 are accepted as space frees.
- Full FIFO, put_vld=1 and get_rdy=1 in the same cycle → only the pop occurs, count 4→3; the push happens next cycle.
- Mid-stream reset with count=3 → count=0, get_vld=0, connected=0; a second prod_key_vld before reset sets key_err; after reset, re-registering "foo" on both sides reconnects.
